// File: rtl/apb_cfg_master.sv
// APB write initiator for the Visible_Watermarking configuration/pixel-load port.
// Commands {last, addr, data} are queued through a valid/ready handshake and
// issued as two-phase APB writes. After a command flagged last, the master
// waits for Image_Done, or gives up after Timeout_Cycles, before continuing.
module apb_cfg_master #(
   parameter int unsigned Amba_Addr_Depth = 20,
   parameter int unsigned Amba_Word       = 16,
   parameter int unsigned Fifo_Depth      = 8,
   parameter int unsigned Timeout_Cycles  = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [Amba_Addr_Depth-1:0] cmd_addr,
   input  logic [Amba_Word-1:0]       cmd_data,
   input  logic                       cmd_last,
   input  logic                       Image_Done,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [Amba_Addr_Depth-1:0] PADDR,
   output logic [Amba_Word-1:0]       PWDATA,
   output logic                       busy,
   output logic                       batch_done,
   output logic                       timeout_err,
   output logic [15:0]                xfer_count
);

   localparam int unsigned PTR_W  = (Fifo_Depth > 1) ? $clog2(Fifo_Depth) : 1;
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned WAIT_W = (Timeout_Cycles > 1) ? $clog2(Timeout_Cycles) : 1;
   localparam int unsigned XFER_W = 16;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_SETUP     = 2'd1,
      S_ACCESS    = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic                       last;
      logic [Amba_Addr_Depth-1:0] addr;
      logic [Amba_Word-1:0]       data;
   } cmd_t;

   // ---------------------------------------------------------------------
   // Command queue
   // ---------------------------------------------------------------------
   cmd_t             mem_q [Fifo_Depth];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             ready_q,  ready_d;
   logic             push_c;
   logic             pop_c;
   logic             not_empty_c;
   cmd_t             cmd_in_c;
   cmd_t             head_c;

   // ---------------------------------------------------------------------
   // Transfer FSM and registered outputs
   // ---------------------------------------------------------------------
   state_t                      state_q,   state_d;
   logic                        psel_q,    psel_d;
   logic                        penable_q, penable_d;
   logic                        pwrite_q,  pwrite_d;
   logic [Amba_Addr_Depth-1:0]  paddr_q,   paddr_d;
   logic [Amba_Word-1:0]        pwdata_q,  pwdata_d;
   logic                        last_q,    last_d;
   logic [WAIT_W-1:0]           wait_q,    wait_d;
   logic [XFER_W-1:0]           xfer_q,    xfer_d;
   logic                        bdone_q,   bdone_d;
   logic                        tmo_q,     tmo_d;
   logic                        busy_q,    busy_d;

   assign cmd_in_c    = '{last: cmd_last, addr: cmd_addr, data: cmd_data};
   assign head_c      = mem_q[rd_ptr_q];
   assign not_empty_c = (count_q != '0);
   assign push_c      = cmd_valid & ready_q;

   // Queue pointer/occupancy bookkeeping; ready and busy look at post-edge occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      ready_d = (count_d != CNT_W'(Fifo_Depth));
      busy_d  = (state_d != S_IDLE) || (count_d != '0);
   end

   // Queue storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (rst && push_c) begin
         mem_q[wr_ptr_q] <= cmd_in_c;
      end
   end

   // Queue control registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   // Next-state and next-output logic; outputs are computed one edge ahead
   always_comb begin
      state_d   = state_q;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      last_d    = last_q;
      wait_d    = wait_q;
      xfer_d    = xfer_q;
      bdone_d   = 1'b0;
      tmo_d     = tmo_q;
      pop_c     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (not_empty_c) begin
               pop_c    = 1'b1;
               paddr_d  = head_c.addr;
               pwdata_d = head_c.data;
               last_d   = head_c.last;
               psel_d   = 1'b1;
               pwrite_d = 1'b1;
               state_d  = S_SETUP;
            end
         end

         S_SETUP: begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
            pwrite_d  = 1'b1;
            state_d   = S_ACCESS;
         end

         S_ACCESS: begin
            xfer_d = xfer_q + XFER_W'(1);
            if (last_q) begin
               wait_d  = '0;
               state_d = S_WAIT_DONE;
            end else if (not_empty_c) begin
               // Back-to-back: PSEL stays high, PENABLE drops for the new SETUP
               pop_c    = 1'b1;
               paddr_d  = head_c.addr;
               pwdata_d = head_c.data;
               last_d   = head_c.last;
               psel_d   = 1'b1;
               pwrite_d = 1'b1;
               state_d  = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_WAIT_DONE: begin
            // Image_Done takes priority over an expiring wait counter
            if (Image_Done) begin
               bdone_d = 1'b1;
               state_d = S_IDLE;
            end else if (wait_q == WAIT_W'(Timeout_Cycles - 1)) begin
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state and registered APB/status outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         last_q    <= 1'b0;
         wait_q    <= '0;
         xfer_q    <= '0;
         bdone_q   <= 1'b0;
         tmo_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         last_q    <= last_d;
         wait_q    <= wait_d;
         xfer_q    <= xfer_d;
         bdone_q   <= bdone_d;
         tmo_q     <= tmo_d;
         busy_q    <= busy_d;
      end
   end

   assign cmd_ready   = ready_q;
   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign busy        = busy_q;
   assign batch_done  = bdone_q;
   assign timeout_err = tmo_q;
   assign xfer_count  = xfer_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Directed bench for apb_cfg_master: a vector table for reset and a single
// write, then hand-timed sequences for batches, a full queue, the wait/timeout
// corner cases and reset in the middle of a transfer.
module tb_apb_cfg_master;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [19:0] cmd_addr;
   logic [15:0] cmd_data;
   logic        cmd_last;
   logic        Image_Done;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [19:0] PADDR;
   logic [15:0] PWDATA;
   logic        busy;
   logic        batch_done;
   logic        timeout_err;
   logic [15:0] xfer_count;

   int pass_cnt = 0;
   int total_cnt = 0;

   apb_cfg_master #(
      .Amba_Addr_Depth(20),
      .Amba_Word      (16),
      .Fifo_Depth     (8),
      .Timeout_Cycles (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .cmd_last   (cmd_last),
      .Image_Done (Image_Done),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .busy       (busy),
      .batch_done (batch_done),
      .timeout_err(timeout_err),
      .xfer_count (xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n, valid, last, done;
      logic [19:0] addr;
      logic [15:0] data;
      logic        e_psel, e_pen, e_pwrite;
      logic [19:0] e_paddr;
      logic [15:0] e_pwdata;
      logic        e_ready, e_busy, e_bd, e_to;
      logic [15:0] e_xfer;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [19:0] a, input logic [15:0] d, input logic l);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_last  = l;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst        = 1'b0;
      cmd_valid  = 1'b0;
      cmd_addr   = '0;
      cmd_data   = '0;
      cmd_last   = 1'b0;
      Image_Done = 1'b0;

      // rst valid last done addr data | psel pen pwrite paddr pwdata ready busy bd to xfer
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 20'h0,    16'h0,    1'b0, 1'b0, 1'b0, 20'h0,  16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 20'h00010, 16'h1234, 1'b0, 1'b0, 1'b0, 20'h0,  16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 20'h0,    16'h0,    1'b1, 1'b0, 1'b1, 20'h10, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 20'h0,    16'h0,    1'b1, 1'b1, 1'b1, 20'h10, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 20'h0,    16'h0,    1'b0, 1'b0, 1'b0, 20'h10, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 20'h0,    16'h0,    1'b0, 1'b0, 1'b0, 20'h10, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};

      // Reset, single write, Image_Done in IDLE ignored
      for (int i = 0; i < 6; i++) begin
         rst        = vecs[i].rst_n;
         cmd_valid  = vecs[i].valid;
         cmd_addr   = vecs[i].addr;
         cmd_data   = vecs[i].data;
         cmd_last   = vecs[i].last;
         Image_Done = vecs[i].done;
         tick();
         chk($sformatf("v%0d_psel", i),   32'(PSEL),        32'(vecs[i].e_psel));
         chk($sformatf("v%0d_pen", i),    32'(PENABLE),     32'(vecs[i].e_pen));
         chk($sformatf("v%0d_pwrite", i), 32'(PWRITE),      32'(vecs[i].e_pwrite));
         chk($sformatf("v%0d_paddr", i),  32'(PADDR),       32'(vecs[i].e_paddr));
         chk($sformatf("v%0d_pwdata", i), 32'(PWDATA),      32'(vecs[i].e_pwdata));
         chk($sformatf("v%0d_ready", i),  32'(cmd_ready),   32'(vecs[i].e_ready));
         chk($sformatf("v%0d_busy", i),   32'(busy),        32'(vecs[i].e_busy));
         chk($sformatf("v%0d_bd", i),     32'(batch_done),  32'(vecs[i].e_bd));
         chk($sformatf("v%0d_to", i),     32'(timeout_err), 32'(vecs[i].e_to));
         chk($sformatf("v%0d_xfer", i),   32'(xfer_count),  32'(vecs[i].e_xfer));
      end
      Image_Done = 1'b0;

      // Batch of three, last on the third, fourth pushed during the wait
      push(20'h00200, 16'hA001, 1'b0);
      push(20'h00204, 16'hA002, 1'b0);
      push(20'h00208, 16'hA003, 1'b1);
      chk("a_c1_access", 32'({PSEL, PENABLE}), 32'h3);
      chk("a_c1_addr", 32'(PADDR), 32'h200);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("a_b2b_psel", 32'(PSEL), 32'd1);
         chk("a_b2b_pen", 32'(PENABLE), 32'(i % 2));
         chk("a_b2b_addr", 32'(PADDR), (i < 2) ? 32'h204 : 32'h208);
         chk("a_b2b_data", 32'(PWDATA), (i < 2) ? 32'hA002 : 32'hA003);
      end
      tick();
      chk("a_wait_psel", 32'(PSEL), 32'd0);
      chk("a_xfer4", 32'(xfer_count), 32'd4);
      for (int j = 0; j < 9; j++) begin
         tick();
         chk("a_wait_apb", 32'({PSEL, PENABLE}), 32'd0);
         chk("a_wait_bd", 32'(batch_done), 32'd0);
         if (j == 0) begin
            cmd_valid = 1'b1;
            cmd_addr  = 20'h0020C;
            cmd_data  = 16'hA004;
            cmd_last  = 1'b0;
         end else begin
            cmd_valid = 1'b0;
         end
      end
      Image_Done = 1'b1;
      tick();
      Image_Done = 1'b0;
      chk("a_bd_pulse", 32'(batch_done), 32'd1);
      chk("a_bd_psel", 32'(PSEL), 32'd0);
      tick();
      chk("a_bd_once", 32'(batch_done), 32'd0);
      chk("a_c4_setup", 32'({PSEL, PENABLE}), 32'h2);
      chk("a_c4_addr", 32'(PADDR), 32'h20C);
      chk("a_c4_data", 32'(PWDATA), 32'hA004);
      tick();
      chk("a_c4_access", 32'({PSEL, PENABLE}), 32'h3);
      tick();
      chk("a_end_psel", 32'(PSEL), 32'd0);
      chk("a_xfer5", 32'(xfer_count), 32'd5);
      chk("a_end_busy", 32'(busy), 32'd0);

      // Fill the queue while waiting for Image_Done, then drain back-to-back
      push(20'h00300, 16'hB000, 1'b1);
      repeat (3) tick();
      chk("b_wait_psel", 32'(PSEL), 32'd0);
      chk("b_wait_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 8; k++) begin
         push(20'(32'h310 + 32'(4 * k)), 16'(32'hB100 + 32'(k)), 1'b0);
         if (k == 6) chk("b_ready_7", 32'(cmd_ready), 32'd1);
      end
      chk("b_ready_full", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b1;
      cmd_addr  = 20'h003FF;
      cmd_data  = 16'hBFFF;
      cmd_last  = 1'b0;
      tick();
      chk("b_hold_ready1", 32'(cmd_ready), 32'd0);
      tick();
      chk("b_hold_ready2", 32'(cmd_ready), 32'd0);
      cmd_valid  = 1'b0;
      Image_Done = 1'b1;
      tick();
      Image_Done = 1'b0;
      chk("b_bd", 32'(batch_done), 32'd1);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("b_psel", 32'(PSEL), 32'd1);
         chk("b_pen", 32'(PENABLE), 32'(i % 2));
         chk("b_addr", 32'(PADDR), 32'h310 + 32'(4 * (i / 2)));
         chk("b_data", 32'(PWDATA), 32'hB100 + 32'(i / 2));
      end
      tick();
      chk("b_end_psel", 32'(PSEL), 32'd0);
      chk("b_xfer14", 32'(xfer_count), 32'd14);
      chk("b_end_busy", 32'(busy), 32'd0);
      chk("b_end_ready", 32'(cmd_ready), 32'd1);

      // Image_Done on the exact timeout cycle wins
      push(20'h00400, 16'hC000, 1'b1);
      repeat (3) tick();
      for (int m = 0; m < 15; m++) begin
         tick();
         chk("e_wait_psel", 32'(PSEL), 32'd0);
         chk("e_wait_busy", 32'(busy), 32'd1);
         chk("e_wait_bd", 32'(batch_done), 32'd0);
      end
      Image_Done = 1'b1;
      tick();
      Image_Done = 1'b0;
      chk("e_bd", 32'(batch_done), 32'd1);
      chk("e_to", 32'(timeout_err), 32'd0);
      chk("e_busy", 32'(busy), 32'd0);
      chk("e_xfer15", 32'(xfer_count), 32'd15);

      // Timeout with no Image_Done: sixteen wait cycles, sticky error
      push(20'h00500, 16'hD000, 1'b1);
      repeat (3) tick();
      for (int m = 0; m < 15; m++) begin
         tick();
         chk("c_wait_busy", 32'(busy), 32'd1);
         chk("c_wait_to", 32'(timeout_err), 32'd0);
         chk("c_wait_bd", 32'(batch_done), 32'd0);
      end
      tick();
      chk("c_idle_busy", 32'(busy), 32'd0);
      chk("c_to_set", 32'(timeout_err), 32'd1);
      chk("c_no_bd", 32'(batch_done), 32'd0);
      chk("c_psel", 32'(PSEL), 32'd0);
      for (int m = 0; m < 3; m++) begin
         tick();
         chk("c_to_sticky", 32'(timeout_err), 32'd1);
         chk("c_no_bd_after", 32'(batch_done), 32'd0);
      end
      chk("c_xfer16", 32'(xfer_count), 32'd16);

      // Reset during ACCESS with three commands still queued
      for (int k = 0; k < 5; k++) begin
         push(20'(32'h600 + 32'(4 * k)), 16'(32'hE000 + 32'(k)), 1'b0);
      end
      chk("d_in_access", 32'({PSEL, PENABLE}), 32'h3);
      chk("d_addr", 32'(PADDR), 32'h604);
      chk("d_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      tick();
      chk("d_rst_apb", 32'({PSEL, PENABLE, PWRITE}), 32'd0);
      chk("d_rst_paddr", 32'(PADDR), 32'd0);
      chk("d_rst_xfer", 32'(xfer_count), 32'd0);
      chk("d_rst_ready", 32'(cmd_ready), 32'd1);
      chk("d_rst_busy", 32'(busy), 32'd0);
      chk("d_rst_to", 32'(timeout_err), 32'd0);
      rst = 1'b1;
      for (int m = 0; m < 6; m++) begin
         tick();
         chk("d_post_psel", 32'(PSEL), 32'd0);
         chk("d_post_busy", 32'(busy), 32'd0);
      end
      chk("d_post_xfer", 32'(xfer_count), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/apb_cfg_master.md
Name: apb_cfg_master

Overview:
- Synthesizable APB write initiator that drives the configuration/pixel-load APB slave port of the Visible_Watermarking core.
- It accepts write commands (address, data, last flag) through a valid/ready queue and issues standard two-phase APB write transfers (SETUP, ACCESS; no PREADY).
- After the command marked last, it waits for the core's Image_Done before starting the next batch.

Parameters:
- Amba_Addr_Depth, 20, APB address width (legal: 20, 24, 32).
- Amba_Word, 16, APB data width (legal: 16, 24, 32).
- Fifo_Depth, 8, command queue entries; power of 2, at least 2.
- Timeout_Cycles, 4096, maximum cycles to wait in WAIT_DONE for Image_Done.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept a command.
- cmd_addr  in  Amba_Addr_Depth  target APB address.
- cmd_data  in  Amba_Word  write data.
- cmd_last  in  1  final command of a batch; wait for Image_Done after it.
- Image_Done  in  1  completion indication from the core.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write (1 in SETUP and ACCESS).
- PADDR  out  Amba_Addr_Depth  APB address.
- PWDATA  out  Amba_Word  APB write data.
- busy  out  1  FSM not IDLE, or queue not empty.
- batch_done  out  1  one-cycle pulse when Image_Done ends WAIT_DONE.
- timeout_err  out  1  sticky; set when a WAIT_DONE times out.
- xfer_count  out  16  completed ACCESS phases; wraps at 65535 -> 0.

Behaviour:
- Reset (rst=0 sampled at an edge): all outputs 0, queue flushed, FSM to IDLE, counters 0. Reset mid-transfer aborts the transfer; PSEL/PENABLE are 0 from the next edge on.
- Queue:
  - Each entry holds {last, addr, data}.
  - cmd_ready = !full, registered from occupancy.
  - Push occurs when cmd_valid & cmd_ready at an edge.
  - When full, cmd_ready=0 and the offered command is not taken; the source must hold it.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
- FSM states: IDLE, SETUP, ACCESS, WAIT_DONE. Outputs are registered.
- IDLE:
  - PSEL=0, PENABLE=0, PWRITE=0; PADDR/PWDATA hold their last values.
  - If the queue is non-empty: pop the head into holding registers and go to SETUP.
  - A command pushed at edge k therefore gives PSEL=1 from edge k+1.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA from holding registers. Next state is ACCESS.
- ACCESS (exactly 1 cycle):
  - PSEL=1, PENABLE=1; PADDR/PWDATA unchanged.
  - xfer_count increments at the end of ACCESS.
  - If the held last=1: go to WAIT_DONE.
  - Else if the queue is non-empty: pop and go directly to SETUP (back-to-back; PSEL stays 1, PENABLE drops to 0, new addr/data).
  - Else: go to IDLE.
- WAIT_DONE:
  - PSEL=0, PENABLE=0; the queue keeps accepting commands but nothing is popped.
  - The wait counter starts at 0 on entry and increments each cycle.
  - Image_Done=1: go to IDLE and pulse batch_done for 1 cycle.
  - Counter reaches Timeout_Cycles-1 with no Image_Done: set timeout_err, go to IDLE, no batch_done pulse.
  - Image_Done on the timeout cycle: Image_Done wins, no error.
- Image_Done outside WAIT_DONE is ignored.
- Throughput: 2 cycles per transfer when back-to-back. N non-last transfers take 2N cycles of PSEL=1.
- PADDR/PWDATA are stable from SETUP through ACCESS. PENABLE is never 1 without PSEL=1.

Test Plan:
- Reset, then single write cmd (0x00010, 0x1234, last=0) -> one cycle PSEL=1/PENABLE=0, next cycle PENABLE=1 with PADDR=0x00010, PWDATA=0x1234; then IDLE; xfer_count=1.
- Push 8 cmds back-to-back (Fifo_Depth=8) -> cmd_ready=0 after the 8th push; 16 consecutive PSEL=1 cycles with PENABLE alternating 0,1; addresses in push order; xfer_count=8.
- Batch of 3 with last on the 3rd; Image_Done pulsed 10 cycles after the 3rd ACCESS -> no APB activity meanwhile; a 4th cmd pushed during the wait is issued only after batch_done pulses once.
- Batch ending last=1 with Timeout_Cycles=16 and no Image_Done -> return to IDLE after 16 WAIT_DONE cycles; timeout_err=1 and stays 1; batch_done never asserts.
- rst=0 asserted during ACCESS with 3 cmds queued -> next edge: PSEL=0, PENABLE=0, xfer_count=0, cmd_ready=1; after release, no transfer occurs.
- Image_Done=1 in IDLE, and Image_Done on the exact timeout cycle -> first ignored (no batch_done); second gives batch_done=1 and timeout_err=0.
